// File: rtl/wf_window_anim.sv
// wf_window_anim: steps window bounds toward targets once per frame and classifies pixels; define WF_ANIM_EN to animate, otherwise targets copy straight across
module wf_window_anim #(
  parameter int STEP = 4,
  parameter int BORDER = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [10:0] tgt_start_x,
  input  logic [10:0] tgt_end_x,
  input  logic [9:0]  tgt_start_y,
  input  logic [9:0]  tgt_end_y,
  input  logic        pix_valid,
  input  logic [10:0] pix_x,
  input  logic [9:0]  pix_y,
  output logic [10:0] cur_start_x,
  output logic [10:0] cur_end_x,
  output logic [9:0]  cur_start_y,
  output logic [9:0]  cur_end_y,
  output logic        busy,
  output logic        win_valid,
  output logic        in_window,
  output logic        on_border
);
  function automatic logic [10:0] step_x(input logic [10:0] c, input logic [10:0] t);
    return t > c ? (t - c > 11'(STEP) ? c + 11'(STEP) : t) : (c - t > 11'(STEP) ? c - 11'(STEP) : t);
  endfunction
  function automatic logic [9:0] step_y(input logic [9:0] c, input logic [9:0] t);
    return t > c ? (t - c > 10'(STEP) ? c + 10'(STEP) : t) : (c - t > 10'(STEP) ? c - 10'(STEP) : t);
  endfunction
  logic [10:0] nx_sx, nx_ex;
  logic [9:0]  nx_sy, nx_ey;
`ifdef WF_ANIM_EN
  typedef enum logic {IDLE, ANIMATE} state_t;
  state_t state;
  assign nx_sx = step_x(cur_start_x, tgt_start_x);
  assign nx_ex = step_x(cur_end_x, tgt_end_x);
  assign nx_sy = step_y(cur_start_y, tgt_start_y);
  assign nx_ey = step_y(cur_end_y, tgt_end_y);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      state <= IDLE;
    else if (frame_tick)
      state <= (nx_sx == tgt_start_x && nx_ex == tgt_end_x && nx_sy == tgt_start_y && nx_ey == tgt_end_y) ? IDLE : ANIMATE;
  assign busy = state == ANIMATE;
`else
  assign nx_sx = tgt_start_x;
  assign nx_ex = tgt_end_x;
  assign nx_sy = tgt_start_y;
  assign nx_ey = tgt_end_y;
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_start_x <= 11'd380;
      cur_end_x   <= 11'd640;
      cur_start_y <= 10'd92;
      cur_end_y   <= 10'd452;
    end else if (frame_tick) begin
      cur_start_x <= nx_sx;
      cur_end_x   <= nx_ex;
      cur_start_y <= nx_sy;
      cur_end_y   <= nx_ey;
    end
  logic in_x, in_y, bord_x, bord_y;
  // Widened compares so start+BORDER and end-BORDER cannot wrap
  assign in_x = pix_x >= cur_start_x && pix_x < cur_end_x;
  assign in_y = pix_y >= cur_start_y && pix_y < cur_end_y;
  assign bord_x = {1'b0, pix_x} < {1'b0, cur_start_x} + 12'(BORDER) || {1'b0, pix_x} + 12'(BORDER) >= {1'b0, cur_end_x};
  assign bord_y = {1'b0, pix_y} < {1'b0, cur_start_y} + 11'(BORDER) || {1'b0, pix_y} + 11'(BORDER) >= {1'b0, cur_end_y};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_valid <= 1'b0;
      in_window <= 1'b0;
      on_border <= 1'b0;
    end else begin
      win_valid <= pix_valid;
      in_window <= pix_valid && in_x && in_y;
      on_border <= pix_valid && in_x && in_y && (bord_x || bord_y);
    end
endmodule

// File: tb/tb_wf_window_anim.sv
// tb_wf_window_anim: randomized bench checking wf_window_anim against a behavioural model every cycle
module tb_wf_window_anim;
  localparam int STEP = 4;
  localparam int BORDER = 2;
  logic clk = 0, rst_n = 0, frame_tick = 0, pix_valid = 0;
  logic [10:0] tgt_start_x = 380, tgt_end_x = 640, pix_x = 0;
  logic [9:0] tgt_start_y = 92, tgt_end_y = 452, pix_y = 0;
  logic [10:0] cur_start_x, cur_end_x;
  logic [9:0] cur_start_y, cur_end_y;
  logic busy, win_valid, in_window, on_border;
  int passed = 0, total = 0;
  int m_cur[4];
  int m_busy, m_wv, m_in, m_ob;
  always #5 clk = ~clk;
  wf_window_anim #(.STEP(STEP), .BORDER(BORDER)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .tgt_start_x(tgt_start_x), .tgt_end_x(tgt_end_x), .tgt_start_y(tgt_start_y), .tgt_end_y(tgt_end_y),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .cur_start_x(cur_start_x), .cur_end_x(cur_end_x), .cur_start_y(cur_start_y), .cur_end_y(cur_end_y),
    .busy(busy), .win_valid(win_valid), .in_window(in_window), .on_border(on_border)
  );
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic int mv(input int c, input int t);
`ifdef WF_ANIM_EN
    return t > c ? c + ((t - c) < STEP ? t - c : STEP) : c - ((c - t) < STEP ? c - t : STEP);
`else
    return t;
`endif
  endfunction
  task automatic model_reset();
    m_cur = '{380, 640, 92, 452};
    m_busy = 0; m_wv = 0; m_in = 0; m_ob = 0;
  endtask
  task automatic model_step();
    int t[4];
    int x, y;
    t = '{int'(tgt_start_x), int'(tgt_end_x), int'(tgt_start_y), int'(tgt_end_y)};
    x = int'(pix_x);
    y = int'(pix_y);
    m_wv = int'(pix_valid);
    m_in = int'(pix_valid && x >= m_cur[0] && x < m_cur[1] && y >= m_cur[2] && y < m_cur[3]);
    m_ob = int'(m_in != 0 && (x < m_cur[0] + BORDER || x >= m_cur[1] - BORDER || y < m_cur[2] + BORDER || y >= m_cur[3] - BORDER));
    if (frame_tick) begin
      m_busy = 0;
      for (int i = 0; i < 4; i++) begin
        m_cur[i] = mv(m_cur[i], t[i]);
`ifdef WF_ANIM_EN
        if (m_cur[i] != t[i]) m_busy = 1;
`endif
      end
    end
  endtask
  task automatic compare_all();
    chk("cur_start_x", cur_start_x, m_cur[0]);
    chk("cur_end_x", cur_end_x, m_cur[1]);
    chk("cur_start_y", cur_start_y, m_cur[2]);
    chk("cur_end_y", cur_end_y, m_cur[3]);
    chk("busy", busy, m_busy);
    chk("win_valid", win_valid, m_wv);
    chk("in_window", in_window, m_in);
    chk("on_border", on_border, m_ob);
  endtask
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic tick();
    frame_tick = 1;
    cycle();
    frame_tick = 0;
  endtask
  task automatic set_tgt(input int sx, input int ex, input int sy, input int ey);
    tgt_start_x = 11'(sx); tgt_end_x = 11'(ex); tgt_start_y = 10'(sy); tgt_end_y = 10'(ey);
  endtask
  task automatic chk_cur(input string name, input int sx, input int ex, input int sy, input int ey);
    chk({name, "_sx"}, cur_start_x, sx);
    chk({name, "_ex"}, cur_end_x, ex);
    chk({name, "_sy"}, cur_start_y, sy);
    chk({name, "_ey"}, cur_end_y, ey);
  endtask
  task automatic async_reset();
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    chk_cur("async_rst", 380, 640, 92, 452);
    chk("async_rst_busy", busy, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int px[5] = '{380, 500, 638, 640, 379};
    int py[5] = '{92, 200, 200, 200, 92};
    int ein[5] = '{1, 1, 1, 0, 0};
    int eob[5] = '{1, 0, 1, 0, 0};
    int n;
    model_reset();
    @(negedge clk);
    compare_all();
    chk_cur("reset", 380, 640, 92, 452);
    chk("reset_busy", busy, 0);
    chk("reset_win_valid", win_valid, 0);
    rst_n = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1; pix_x = 11'(px[i]); pix_y = 10'(py[i]);
      cycle();
      chk("pix_in_window", in_window, ein[i]);
      chk("pix_on_border", on_border, eob[i]);
      chk("pix_win_valid", win_valid, 1);
    end
    pix_valid = 0;
    cycle();
    chk("pix_idle_in_window", in_window, 0);
    set_tgt(88, 888, 30, 512);
    tick();
`ifdef WF_ANIM_EN
    chk_cur("tick1", 376, 644, 88, 456);
    chk("tick1_busy", busy, 1);
`else
    chk_cur("tick1", 88, 888, 30, 512);
    chk("tick1_busy", busy, 0);
`endif
    for (int k = 2; k <= 73; k++) begin
      tick();
`ifdef WF_ANIM_EN
      if (k == 15) chk("tick15_sy", cur_start_y, 32);
      if (k == 72) chk("tick72_busy", busy, 1);
`endif
      if (k == 16) chk("tick16_sy", cur_start_y, 30);
    end
    chk("tick73_busy", busy, 0);
    chk_cur("tick73", 88, 888, 30, 512);
    set_tgt(500, 600, 100, 200);
    repeat (5) cycle();
    chk_cur("no_tick", 88, 888, 30, 512);
    set_tgt(0, 1280, 0, 720);
    repeat (10) tick();
    set_tgt(380, 640, 92, 452);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 200);
    chk("retarget_settled", int'(busy == 0), 1);
    chk_cur("retarget", 380, 640, 92, 452);
    set_tgt(88, 888, 30, 512);
    repeat (5) tick();
    async_reset();
    cycle();
    rst_n = 1;
    repeat (3) cycle();
    chk_cur("post_rst_hold", 380, 640, 92, 452);
    tick();
`ifdef WF_ANIM_EN
    chk("post_rst_tick_sx", cur_start_x, 376);
`else
    chk("post_rst_tick_sx", cur_start_x, 88);
`endif
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        int sx, sy;
        sx = int'($urandom_range(0, 2000));
        sy = int'($urandom_range(0, 1000));
        set_tgt(sx, int'($urandom_range(sx + 1, 2047)), sy, int'($urandom_range(sy + 1, 1023)));
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        @(negedge clk);
        rst_n = 1;
      end
      frame_tick = $urandom_range(0, 3) == 0;
      pix_valid = $urandom_range(0, 3) != 0;
      n = m_cur[$urandom_range(0, 1)] + int'($urandom_range(0, 6)) - 3;
      pix_x = 11'(n < 0 ? 0 : n > 2047 ? 2047 : n);
      n = $urandom_range(0, 1) ? int'($urandom_range(0, 1023)) : m_cur[2 + $urandom_range(0, 1)] + int'($urandom_range(0, 6)) - 3;
      pix_y = 10'(n < 0 ? 0 : n > 1023 ? 1023 : n);
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
